// File: rtl/bcd_counter_n.sv
// Multi-digit packed-BCD counter with load, enable, terminal-count pulse and wrap/saturate option.
// Define BCD_COUNTER_DOWN_EN to add the iUp port and down counting.
module bcd_counter_n #(
   parameter int DIGITS = 2,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  iClk,
   input  logic                  iRst_n,
   input  logic                  iEn,
   input  logic                  iLoad,
   input  logic [4*DIGITS-1:0]   iLoadVal,
`ifdef BCD_COUNTER_DOWN_EN
   input  logic                  iUp,
`endif
   output logic [4*DIGITS-1:0]   oCount,
   output logic                  oTc
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0] count_q, count_d;
   logic         tc_q, tc_d;
   logic         up;
   logic         at_term;

   // Out-of-range nibbles are forced to 0 so the count register only ever holds digits 0..9.
   function automatic logic [W-1:0] bcd_sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic dir_up);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (dir_up) begin
               if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
               else begin
                  r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
               else begin
                  r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   function automatic logic bcd_is_term(input logic [W-1:0] v, input logic dir_up);
      logic t;
      t = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != (dir_up ? 4'd9 : 4'd0)) t = 1'b0;
      end
      return t;
   endfunction

`ifdef BCD_COUNTER_DOWN_EN
   assign up = iUp;
`else
   assign up = 1'b1;
`endif

   assign at_term = bcd_is_term(count_q, up);

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (iLoad) begin
         count_d = bcd_sanitize(iLoadVal);
      end else if (iEn) begin
         tc_d = at_term;
         // Saturating mode parks on the terminal value; the pulse still fires every counted edge there.
         if (!(at_term && !WRAP)) count_d = bcd_step(count_q, up);
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         count_q <= '0;
         tc_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
      end
   end

   assign oCount = count_q;
   assign oTc    = tc_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Directed testbench for bcd_counter_n: 2-digit wrap, 2-digit saturate and 4-digit instances share stimulus.
// Down-count vectors are included when BCD_COUNTER_DOWN_EN is defined.
module tb_bcd_counter_n;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        load;
   logic [7:0]  loadval2;
   logic [15:0] loadval4;
`ifdef BCD_COUNTER_DOWN_EN
   logic        up;
`endif
   logic [7:0]  cnt_w, cnt_s;
   logic [15:0] cnt_4;
   logic        tc_w, tc_s, tc_4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_wrap (
      .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLoad(load), .iLoadVal(loadval2),
`ifdef BCD_COUNTER_DOWN_EN
      .iUp(up),
`endif
      .oCount(cnt_w), .oTc(tc_w));

   bcd_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_sat (
      .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLoad(load), .iLoadVal(loadval2),
`ifdef BCD_COUNTER_DOWN_EN
      .iUp(up),
`endif
      .oCount(cnt_s), .oTc(tc_s));

   bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_d4 (
      .iClk(clk), .iRst_n(rst_n), .iEn(en), .iLoad(load), .iLoadVal(loadval4),
`ifdef BCD_COUNTER_DOWN_EN
      .iUp(up),
`endif
      .oCount(cnt_4), .oTc(tc_4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp;
      int v;
      rst_n    = 1'b0;
      en       = 1'b1;
      load     = 1'b1;
      loadval2 = 8'h55;
      loadval4 = 16'h5555;
`ifdef BCD_COUNTER_DOWN_EN
      up       = 1'b1;
`endif
      #3;
      chk("rst_cnt_w", cnt_w, 8'h00);
      chk("rst_tc_w", tc_w, 1'b0);
      chk("rst_cnt_4", cnt_4, 16'h0000);
      step();
      step();
      chk("rst_ignores_load", cnt_w, 8'h00);
      load = 1'b0;
      en   = 1'b0;
      rst_n = 1'b1;
      step();
      chk("release_no_action", cnt_w, 8'h00);

      // Full up-count cycle with wrap
      en = 1'b1;
      for (int i = 1; i <= 100; i++) begin
         step();
         v   = i % 100;
         exp = ((v / 10) << 4) | (v % 10);
         chk($sformatf("wrap_cnt_%0d", i), cnt_w, exp);
         chk($sformatf("wrap_tc_%0d", i), tc_w, (i == 100) ? 1 : 0);
      end
      chk("sat_after_100_cnt", cnt_s, 8'h99);
      chk("sat_after_100_tc", tc_s, 1'b1);

      en = 1'b0;
      step();
      chk("hold_cnt", cnt_w, 8'h00);
      chk("hold_tc", tc_w, 1'b0);
      step();
      chk("hold_cnt2", cnt_w, 8'h00);

      // Load with illegal low nibble and enable on the same edge
      load = 1'b1; en = 1'b1; loadval2 = 8'h3C;
      step();
      chk("load3C_cnt", cnt_w, 8'h30);
      chk("load3C_tc", tc_w, 1'b0);
      load = 1'b0;
      step();
      chk("after3C_cnt", cnt_w, 8'h31);

      loadval2 = 8'hA5; load = 1'b1;
      step();
      chk("loadA5_cnt", cnt_w, 8'h05);
      loadval2 = 8'hFF;
      step();
      chk("loadFF_cnt", cnt_w, 8'h00);

      // Saturating instance from 98
      loadval2 = 8'h98; load = 1'b1;
      step();
      chk("sat_load98", cnt_s, 8'h98);
      load = 1'b0;
      step();
      chk("sat_e1_cnt", cnt_s, 8'h99);
      chk("sat_e1_tc", tc_s, 1'b0);
      step();
      chk("sat_e2_cnt", cnt_s, 8'h99);
      chk("sat_e2_tc", tc_s, 1'b1);
      chk("wrap_e2_cnt", cnt_w, 8'h00);
      chk("wrap_e2_tc", tc_w, 1'b1);
      step();
      chk("sat_e3_cnt", cnt_s, 8'h99);
      chk("sat_e3_tc", tc_s, 1'b1);
      loadval2 = 8'h99; load = 1'b1;
      step();
      chk("load_term_clears_tc", tc_s, 1'b0);
      chk("load_term_cnt", cnt_s, 8'h99);

      // Asynchronous reset mid-count
      loadval2 = 8'h46;
      step();
      load = 1'b0;
      step();
      chk("pre_rst_47", cnt_w, 8'h47);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", cnt_w, 8'h00);
      chk("async_rst_tc", tc_w, 1'b0);
      step();
      chk("rst_held_cnt", cnt_w, 8'h00);
      rst_n = 1'b1;
      step();
      chk("resume_cnt", cnt_w, 8'h01);

      // Four-digit ripple carry
      loadval4 = 16'h0999; load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("d4_1000_cnt", cnt_4, 16'h1000);
      chk("d4_1000_tc", tc_4, 1'b0);
      loadval4 = 16'h9999; load = 1'b1;
      step();
      chk("d4_load9999_tc", tc_4, 1'b0);
      load = 1'b0;
      step();
      chk("d4_wrap_cnt", cnt_4, 16'h0000);
      chk("d4_wrap_tc", tc_4, 1'b1);

`ifdef BCD_COUNTER_DOWN_EN
      up = 1'b0; loadval2 = 8'h01; load = 1'b1;
      step();
      load = 1'b0;
      step();
      chk("dn_e1_cnt", cnt_w, 8'h00);
      chk("dn_e1_tc", tc_w, 1'b0);
      step();
      chk("dn_e2_cnt", cnt_w, 8'h99);
      chk("dn_e2_tc", tc_w, 1'b1);
      chk("dn_sat_cnt", cnt_s, 8'h00);
      chk("dn_sat_tc", tc_s, 1'b1);
      step();
      chk("dn_e3_cnt", cnt_w, 8'h98);
      chk("dn_e3_tc", tc_w, 1'b0);
      up = 1'b1;
      step();
      chk("dir_change_cnt", cnt_w, 8'h99);
      chk("dir_change_tc", tc_w, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_counter_n.md
BCD_COUNTER_N -- requirements
Module: bcd_counter_n

Interface
REQ-001 SHALL have parameter: DIGITS, 2, number of BCD digits, legal range 1..8.
REQ-002 SHALL have parameter: WRAP, 1, 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-003 SHALL have port: iClk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: iRst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: iEn  input  1  count enable, sampled on the rising edge of iClk.
REQ-006 SHALL have port: iLoad  input  1  synchronous load strobe.
REQ-007 SHALL have port: iLoadVal  input  4*DIGITS  load value, packed BCD; digit 0 in bits [3:0].
REQ-008 SHALL have port: iUp  input  1  direction, 1 = up, 0 = down; present only with BCD_COUNTER_DOWN_EN.
REQ-009 SHALL have port: oCount  output  4*DIGITS  registered packed BCD count; digit 0 least significant.
REQ-010 SHALL have port: oTc  output  1  registered terminal-count pulse.

Function
REQ-011 Each rising edge SHALL apply exactly one action, in priority order: load, count, hold.
REQ-012 With iLoad=1, oCount SHALL take iLoadVal on that edge, iEn ignored.
REQ-013 A loaded nibble greater than 9 SHALL be stored as 0; other nibbles load unchanged.
REQ-014 With iLoad=0 and iEn=1, the count SHALL step by exactly 1 in decimal per edge.
REQ-015 Counting up: digit 0 increments; a digit at 9 SHALL go to 0 and carry into the next digit in the same edge; carries ripple through all DIGITS within one cycle.
REQ-016 Up-count terminal value SHALL be all digits 9, e.g. 99 for DIGITS=2.
REQ-017 Enabled up-count at terminal with WRAP=1 SHALL give all zeros; with WRAP=0 oCount SHALL hold at terminal.
REQ-018 With iLoad=0 and iEn=0, oCount SHALL hold.
REQ-019 oTc SHALL be 1 for the cycle after any edge where a count was applied with oCount at terminal value, and 0 otherwise, in both WRAP modes.
REQ-020 A load edge SHALL clear oTc, even if the loaded value is terminal.
REQ-021 oCount SHALL never hold a nibble above 9.
REQ-022 Latency: a load or count on edge N SHALL be visible on oCount and oTc after edge N; no combinational path from inputs to outputs.

Reset
REQ-023 iRst_n=0 SHALL immediately and asynchronously force oCount to 0 and oTc to 0, independent of iClk.
REQ-024 While iRst_n=0, iEn, iLoad and iUp SHALL be ignored.
REQ-025 Reset asserted mid-count SHALL abandon the count; after release the first enabled edge SHALL give oCount=1 when counting up.
REQ-026 Release of iRst_n SHALL be treated as synchronous to iClk; no action SHALL occur until the first rising edge after release.

Configuration
REQ-027 Macro BCD_COUNTER_DOWN_EN SHALL compile in the iUp port and down counting.
REQ-028 With BCD_COUNTER_DOWN_EN and iUp=0: a digit at 0 SHALL go to 9 and borrow from the next digit; terminal value SHALL be all zeros.
REQ-029 With BCD_COUNTER_DOWN_EN, enabled down-count at 0 SHALL give all 9s when WRAP=1 and hold 0 when WRAP=0; oTc SHALL follow REQ-019 using the down terminal.
REQ-030 With BCD_COUNTER_DOWN_EN, a change of iUp SHALL take effect on the next edge with no extra latency or lost count.
REQ-031 Without BCD_COUNTER_DOWN_EN, iUp SHALL not exist and the block SHALL count up only.

Verification (DIGITS=2 unless stated)
REQ-032 Reset, then iEn=1 for 100 edges -> oCount 00,01..09,10..99,00; oTc=1 only in the cycle oCount shows 00 after 99.
REQ-033 WRAP=0, load 98, iEn=1 for 3 edges -> oCount 99,99,99; oTc=1 after the 2nd and 3rd edges.
REQ-034 Load 0x3C with iEn=1 on the same edge -> oCount=30, oTc=0; next enabled edge -> 31.
REQ-035 Count to 47, then assert iRst_n=0 between clock edges -> oCount=00 and oTc=0 before the next edge; count resumes from 00 after release.
REQ-036 BCD_COUNTER_DOWN_EN, WRAP=1, load 01, iUp=0, iEn=1 for 3 edges -> 00,99,98; oTc=1 only in the cycle oCount shows 99.
REQ-037 DIGITS=4, load 0999, one enabled up edge -> oCount=1000; load 9999, one enabled up edge -> oCount=0000, oTc=1.
